// File: rtl/serin_receiver.sv
// serin_receiver
//    Serial-input receiver. It turns 10-bit SID frames into the SERIN byte.
//    A frame is a start bit (0), 8 data bits sent LSB first, and a stop bit (1).
//    It also makes the status strobes and levels that feed SKSTAT, the serial-in
//    interrupt, and the timer-restart pulse for channels 3/4.
//    All protocol state advances only on the 1.79MHz enable (en). Only the sid
//    synchroniser is clocked on every clk.
//
// Ports
//    clk        in   system clock
//    reset      in   synchronous active-high reset
//    en         in   one-clk-wide 1.79MHz enable
//    sid        in   raw serial-in pin, idle high
//    bitTick    in   bit-centre sample strobe from the ch4 timer (only used with en)
//    asyncMode  in   1 = a start-bit falling edge restarts the timers
//    initMode   in   hold the receiver idle (like reset, but serinData is kept)
//    addrRd     in   CPU read of SERIN (only used with en); clears the byte-full flag
//    serinData  out  last byte received
//    serinIrq   out  one-clk pulse when a byte completes
//    sdiOvrun   out  one-clk pulse when a byte completes while the previous byte is unread
//    setFramer  out  one-clk pulse when the stop bit is sampled as 0
//    sdiBusy    out  level, high while a frame is in progress
//    siDelay    out  synchronised sid, registered on en
//    timerSync  out  one-clk pulse that restarts the ch3/ch4 timers on an async start edge
module serin_receiver #(
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       en,
   input  logic       sid,
   input  logic       bitTick,
   input  logic       asyncMode,
   input  logic       initMode,
   input  logic       addrRd,
   output logic [7:0] serinData,
   output logic       serinIrq,
   output logic       sdiOvrun,
   output logic       setFramer,
   output logic       sdiBusy,
   output logic       siDelay,
   output logic       timerSync
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } state_t;

   state_t                 state_q;
   logic [SYNC_STAGES-1:0] sync_q;
   logic [7:0]             shift_q;
   logic [7:0]             data_q;
   logic [2:0]             bit_cnt_q;
   logic                   full_q;
   logic                   full_d;
   logic                   irq_q;
   logic                   ovrun_q;
   logic                   framer_q;
   logic                   busy_q;
   logic                   si_delay_q;
   logic                   tsync_q;

   logic sid_s;
   logic tick;
   logic stop_done;

   // Metastability synchroniser. Each stage presets to 1 because the pin idles high.
   // A preset to 0 would look like a start edge as soon as reset is released.
   always_ff @(posedge clk) begin
      if (reset || initMode) begin
         sync_q <= '1;
      end else begin
         sync_q[0] <= sid;
      end
   end

   for (genvar gi = 1; gi < SYNC_STAGES; gi++) begin : g_sync
      always_ff @(posedge clk) begin
         if (reset || initMode) begin
            sync_q[gi] <= 1'b1;
         end else begin
            sync_q[gi] <= sync_q[gi-1];
         end
      end
   end

   assign sid_s     = sync_q[SYNC_STAGES-1];
   assign tick      = en & bitTick;
   assign stop_done = tick && (state_q == ST_STOP);

   // Byte-full flag. When a completion and a CPU read happen in the same cycle,
   // the completion wins so the new byte is still flagged as unread.
   always_comb begin
      full_d = full_q;
      if (en && addrRd) begin
         full_d = 1'b0;
      end
      if (stop_done) begin
         full_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset || initMode) begin
         state_q    <= ST_IDLE;
         shift_q    <= 8'h00;
         bit_cnt_q  <= 3'd0;
         full_q     <= 1'b0;
         irq_q      <= 1'b0;
         ovrun_q    <= 1'b0;
         framer_q   <= 1'b0;
         busy_q     <= 1'b0;
         si_delay_q <= 1'b1;
         tsync_q    <= 1'b0;
         // initMode keeps the last received byte readable.
         if (reset) begin
            data_q <= 8'h00;
         end
      end else begin
         // Pulse outputs are high for one clk only.
         irq_q    <= 1'b0;
         ovrun_q  <= 1'b0;
         framer_q <= 1'b0;
         tsync_q  <= 1'b0;
         busy_q   <= (state_q != ST_IDLE);
         full_q   <= full_d;

         if (en) begin
            si_delay_q <= sid_s;
            case (state_q)
               ST_IDLE: begin
                  if (asyncMode) begin
                     // The falling edge is seen between two en samples.
                     if (si_delay_q && !sid_s) begin
                        tsync_q <= 1'b1;
                        state_q <= ST_START;
                     end
                  end else if (bitTick && !sid_s) begin
                     // Sync mode: this tick samples the start bit itself.
                     bit_cnt_q <= 3'd0;
                     state_q   <= ST_DATA;
                  end
               end
               ST_START: begin
                  if (bitTick) begin
                     if (!sid_s) begin
                        bit_cnt_q <= 3'd0;
                        state_q   <= ST_DATA;
                     end else begin
                        state_q <= ST_IDLE;
                     end
                  end
               end
               ST_DATA: begin
                  if (bitTick) begin
                     shift_q   <= {sid_s, shift_q[7:1]};
                     bit_cnt_q <= bit_cnt_q + 3'd1;
                     if (bit_cnt_q == 3'd7) begin
                        state_q <= ST_STOP;
                     end
                  end
               end
               ST_STOP: begin
                  if (bitTick) begin
                     // The byte is stored even on overrun or framing error.
                     data_q   <= shift_q;
                     irq_q    <= 1'b1;
                     ovrun_q  <= full_q;
                     framer_q <= ~sid_s;
                     state_q  <= ST_IDLE;
                  end
               end
               default: state_q <= ST_IDLE;
            endcase
         end
      end
   end

   assign serinData = data_q;
   assign serinIrq  = irq_q;
   assign sdiOvrun  = ovrun_q;
   assign setFramer = framer_q;
   assign sdiBusy   = busy_q;
   assign siDelay   = si_delay_q;
   assign timerSync = tsync_q;

endmodule

// File: tb/tb_serin_receiver.sv
// tb_serin_receiver
//    Scoreboard bench for serin_receiver. The stimulus tasks send whole frames.
//    At each stop bit they push the expected byte, overrun and framing flags.
//    The expected values come from a frame-level model: one byte-full flag, and
//    an expected timer-restart count for asynchronous start edges.
//    A separate monitor pops and compares whenever serinIrq is high.
module tb_serin_receiver;

   localparam int SYNC = 2;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       en = 1'b0;
   logic       sid = 1'b1;
   logic       bitTick = 1'b0;
   logic       asyncMode = 1'b1;
   logic       initMode = 1'b0;
   logic       addrRd = 1'b0;
   logic [7:0] serinData;
   logic       serinIrq;
   logic       sdiOvrun;
   logic       setFramer;
   logic       sdiBusy;
   logic       siDelay;
   logic       timerSync;

   serin_receiver #(.SYNC_STAGES(SYNC)) dut (
      .clk       (clk),
      .reset     (reset),
      .en        (en),
      .sid       (sid),
      .bitTick   (bitTick),
      .asyncMode (asyncMode),
      .initMode  (initMode),
      .addrRd    (addrRd),
      .serinData (serinData),
      .serinIrq  (serinIrq),
      .sdiOvrun  (sdiOvrun),
      .setFramer (setFramer),
      .sdiBusy   (sdiBusy),
      .siDelay   (siDelay),
      .timerSync (timerSync)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] d;
      logic       ovr;
      logic       fr;
   } exp_t;

   exp_t       exp_q[$];
   exp_t       mon_e;
   int         total = 0;
   int         bad = 0;
   bit         mon_on = 1'b0;
   logic       irq_prev = 1'b0;
   logic       ts_prev = 1'b0;
   int         ts_seen = 0;
   int         busy_ticks = 0;
   // Frame-level reference state
   bit         model_full = 1'b0;
   logic [7:0] model_data = 8'h00;
   int         exp_ts = 0;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end else begin
         $display("ok   %s: %0h", name, act);
      end
   endfunction

   // Monitor: compare every completed byte against the scoreboard.
   always @(negedge clk) begin
      if (mon_on) begin
         if (serinIrq) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_irq: got serinIrq=1 data=%0h expected no byte", serinData);
            end else begin
               mon_e = exp_q.pop_front();
               $display("byte done: data=%0h ovr=%0b fr=%0b", serinData, sdiOvrun, setFramer);
               chk("serinData", {24'd0, serinData}, {24'd0, mon_e.d});
               chk("sdiOvrun", {31'd0, sdiOvrun}, {31'd0, mon_e.ovr});
               chk("setFramer", {31'd0, setFramer}, {31'd0, mon_e.fr});
            end
            if (irq_prev) begin
               total++;
               bad++;
               $display("FAIL irq_width: got serinIrq high 2 clks expected 1");
            end
         end else if (sdiOvrun || setFramer) begin
            total++;
            bad++;
            $display("FAIL stray_pulse: got ovr=%0b fr=%0b expected 0 without serinIrq", sdiOvrun, setFramer);
         end
         if (timerSync) begin
            ts_seen++;
            if (ts_prev) begin
               total++;
               bad++;
               $display("FAIL tsync_width: got timerSync high 2 clks expected 1");
            end
         end
         if (en && bitTick && sdiBusy) busy_ticks++;
         irq_prev = serinIrq;
         ts_prev  = timerSync;
      end
   end

   // Drive one clk cycle. Inputs change just after the active edge.
   task automatic cyc(input logic e, input logic t, input logic r);
      en      = e;
      bitTick = t;
      addrRd  = r;
      @(posedge clk);
      #1;
      en      = 1'b0;
      bitTick = 1'b0;
      addrRd  = 1'b0;
   endtask

   // Drive one en slot: sid settles for 3 clks, then one clk with en high.
   task automatic step_en(input logic s, input logic t, input logic r);
      sid = s;
      repeat (3) cyc(1'b0, 1'b0, 1'b0);
      cyc(1'b1, t, r);
   endtask

   task automatic do_read();
      step_en(1'b1, 1'b0, 1'b1);
      model_full = 1'b0;
   endtask

   // Send a frame in 4 en slots per bit, with the tick on slot 2.
   // nb < 10 stops early; the caller then aborts the frame.
   task automatic send_frame(input logic [7:0] b, input logic stopb, input logic rd_stop,
                             input int idle, input int nb);
      logic [9:0] bits;
      int         bt0;
      bits = {stopb, b, 1'b0};
      for (int i = 0; i < idle; i++) step_en(1'b1, 1'b0, 1'b0);
      bt0 = busy_ticks;
      if (asyncMode) exp_ts++;
      for (int i = 0; i < nb; i++) begin
         for (int k = 0; k < 4; k++) begin
            if (i == 9 && k == 2) begin
               exp_q.push_back('{d: b, ovr: model_full, fr: ~stopb});
               model_full = 1'b1;
               model_data = b;
               step_en(bits[i], 1'b1, rd_stop);
            end else begin
               step_en(bits[i], k == 2, 1'b0);
            end
            if (i == 0 && k == 3) chk("busy_in_frame", {31'd0, sdiBusy}, 32'd1);
         end
      end
      if (nb == 10) begin
         step_en(1'b1, 1'b0, 1'b0);
         chk("busy_after_frame", {31'd0, sdiBusy}, 32'd0);
         chk("busy_ticks", busy_ticks - bt0, asyncMode ? 32'd10 : 32'd9);
         chk("timerSync_count", ts_seen, exp_ts);
      end
   endtask

   initial begin
      logic [7:0] rb;
      logic       rstop;
      logic       prev_stop;
      int         ridle;

      repeat (4) cyc(1'b0, 1'b0, 1'b0);
      chk("rst_serinData", {24'd0, serinData}, 32'd0);
      chk("rst_sdiBusy", {31'd0, sdiBusy}, 32'd0);
      chk("rst_siDelay", {31'd0, siDelay}, 32'd1);
      chk("rst_serinIrq", {31'd0, serinIrq}, 32'd0);
      reset  = 1'b0;
      mon_on = 1'b1;

      // Async frame 0xA5
      send_frame(8'hA5, 1'b1, 1'b0, 2, 10);
      // Overrun, then no overrun when the byte is read between frames
      send_frame(8'h3C, 1'b1, 1'b0, 2, 10);
      send_frame(8'hC3, 1'b1, 1'b0, 2, 10);
      do_read();
      send_frame(8'h3C, 1'b1, 1'b0, 2, 10);
      do_read();
      send_frame(8'hC3, 1'b1, 1'b0, 2, 10);
      // Framing error
      send_frame(8'h55, 1'b0, 1'b0, 2, 10);

      // Glitch: sid low for less than one bit, then the tick sees a 1 in START
      step_en(1'b1, 1'b0, 1'b0);
      step_en(1'b1, 1'b0, 1'b0);
      step_en(1'b0, 1'b0, 1'b0);
      exp_ts++;
      step_en(1'b1, 1'b0, 1'b0);
      chk("glitch_busy_hi", {31'd0, sdiBusy}, 32'd1);
      step_en(1'b1, 1'b1, 1'b0);
      step_en(1'b1, 1'b0, 1'b0);
      chk("glitch_busy_lo", {31'd0, sdiBusy}, 32'd0);
      chk("glitch_tsync", ts_seen, exp_ts);

      // Reset after 4 data bits
      send_frame(8'hF0, 1'b1, 1'b0, 2, 5);
      reset = 1'b1;
      sid   = 1'b1;
      cyc(1'b0, 1'b0, 1'b0);
      chk("reset_busy", {31'd0, sdiBusy}, 32'd0);
      chk("reset_data", {24'd0, serinData}, 32'd0);
      cyc(1'b0, 1'b0, 1'b0);
      reset      = 1'b0;
      model_full = 1'b0;
      model_data = 8'h00;
      send_frame(8'h81, 1'b1, 1'b0, 2, 10);

      // initMode after 4 data bits keeps serinData and clears full
      send_frame(8'h0F, 1'b1, 1'b0, 2, 5);
      initMode = 1'b1;
      sid      = 1'b1;
      cyc(1'b0, 1'b0, 1'b0);
      chk("init_busy", {31'd0, sdiBusy}, 32'd0);
      cyc(1'b1, 1'b1, 1'b0);
      chk("init_data", {24'd0, serinData}, {24'd0, model_data});
      initMode   = 1'b0;
      model_full = 1'b0;
      send_frame(8'h81, 1'b1, 1'b0, 2, 10);

      // Read at the same tick as a completion while full=0, then a real overrun
      do_read();
      send_frame(8'h42, 1'b1, 1'b1, 2, 10);
      send_frame(8'h24, 1'b1, 1'b0, 2, 10);

      // siDelay alignment: SYNC clks of synchroniser delay, then the next en
      asyncMode = 1'b0;
      step_en(1'b1, 1'b0, 1'b0);
      sid = 1'b0;
      repeat (SYNC - 1) cyc(1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0);
      chk("siDelay_early", {31'd0, siDelay}, 32'd1);
      cyc(1'b1, 1'b0, 1'b0);
      chk("siDelay_low", {31'd0, siDelay}, 32'd0);
      sid = 1'b1;
      repeat (4) cyc(1'b0, 1'b0, 1'b0);
      chk("siDelay_hold", {31'd0, siDelay}, 32'd0);
      cyc(1'b1, 1'b0, 1'b0);
      chk("siDelay_high", {31'd0, siDelay}, 32'd1);

      // Sync-mode frame, then randomised frames in mixed modes
      send_frame(8'h81, 1'b1, 1'b0, 1, 10);
      prev_stop = 1'b1;
      for (int n = 0; n < 20; n++) begin
         rb        = 8'($urandom);
         rstop     = ($urandom_range(0, 3) != 0);
         asyncMode = 1'($urandom);
         ridle     = $urandom_range(0, 2);
         // After a 0 stop bit an async start edge needs an idle-high slot first.
         if (!prev_stop && ridle == 0) ridle = 1;
         if ($urandom_range(0, 2) == 0) do_read();
         send_frame(rb, rstop, 1'($urandom), ridle, 10);
         prev_stop = rstop;
      end

      step_en(1'b1, 1'b0, 1'b0);
      chk("scoreboard_empty", exp_q.size(), 32'd0);
      chk("timerSync_total", ts_seen, exp_ts);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
